// File: rtl/es_mem_stream_reader_if.sv
// Bundles the control, RAM-read and streaming signals of the memory stream reader.
// The reader uses the slave view; the environment driving it uses the master view.
interface es_mem_stream_reader_if #(
    parameter int ADDR_W = 15
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] length;
    logic              busy;
    logic              done;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic              mem_clken;
    logic [31:0]       mem_readdata;

    logic [31:0]       st_data;
    logic              st_valid;
    logic              st_ready;
    logic              st_startofpacket;
    logic              st_endofpacket;

    modport slave (
        input  start, abort, base_addr, length, mem_readdata, st_ready,
        output busy, done, mem_address, mem_chipselect, mem_write, mem_byteenable,
               mem_clken, st_data, st_valid, st_startofpacket, st_endofpacket
    );

    modport master (
        output start, abort, base_addr, length, mem_readdata, st_ready,
        input  busy, done, mem_address, mem_chipselect, mem_write, mem_byteenable,
               mem_clken, st_data, st_valid, st_startofpacket, st_endofpacket
    );
endinterface

// File: rtl/es_mem_stream_reader.sv
// Streams a block of consecutive RAM words (wrapping at MEM_WORDS) out as one sop/eop packet.
// First beat 2 cycles after start, 1 word/cycle; reads throttled so buffered + in-flight never exceed FIFO_DEPTH.
module es_mem_stream_reader #(
    parameter int MEM_WORDS  = 25000,
    parameter int ADDR_W     = 15,
    parameter int FIFO_DEPTH = 4
) (
    input logic                   clk,
    input logic                   reset,
    es_mem_stream_reader_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state_q;
    logic              done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] issued_q;
    logic [ADDR_W-1:0] out_cnt_q;
    logic              inflight_q;

    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  occ_q;

    logic              start_accept;
    logic              flush;
    logic              issue;
    logic              push;
    logic              pop;
    logic              fifo_nempty;
    logic [ADDR_W-1:0] next_addr;

    assign start_accept = (state_q == IDLE) && bus.start && !bus.abort && (bus.length != '0);
    assign flush        = (state_q != IDLE) && bus.abort;
    assign fifo_nempty  = (occ_q != '0);

    // The read issued this cycle lands one cycle later, so it is counted against free space now.
    assign issue = (state_q == RUN) && (issued_q != len_q) &&
                   ((occ_q + CNT_W'(inflight_q)) < DEPTH_C);
    assign push  = inflight_q;
    assign pop   = fifo_nempty && bus.st_ready;

    assign next_addr = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);

    assign bus.busy             = (state_q != IDLE);
    assign bus.done             = done_q;
    assign bus.mem_address      = addr_q;
    assign bus.mem_chipselect   = issue;
    assign bus.mem_write        = 1'b0;
    assign bus.mem_byteenable   = 4'hF;
    assign bus.mem_clken        = 1'b1;
    assign bus.st_data          = fifo_mem[rd_ptr_q];
    assign bus.st_valid         = fifo_nempty;
    assign bus.st_startofpacket = fifo_nempty && (out_cnt_q == '0);
    assign bus.st_endofpacket   = fifo_nempty && (out_cnt_q == len_q - ADDR_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        if (bus.length == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q  <= RUN;
                            addr_q   <= bus.base_addr;
                            len_q    <= bus.length;
                            issued_q <= '0;
                        end
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                    end else if (issue) begin
                        addr_q   <= next_addr;
                        issued_q <= issued_q + ADDR_W'(1);
                        if (issued_q + ADDR_W'(1) == len_q) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                    end else if (!fifo_nempty && !inflight_q) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Abort drops both the buffered words and the return of the read still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            out_cnt_q  <= '0;
        end else if (flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            occ_q <= occ_q + CNT_W'(push) - CNT_W'(pop);
            if (start_accept) begin
                out_cnt_q <= '0;
            end else if (pop) begin
                out_cnt_q <= out_cnt_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.mem_readdata;
        end
    end
endmodule

// File: tb/tb_es_mem_stream_reader.sv
// Scoreboard bench for es_mem_stream_reader: directed transfers against a RAM holding word[n]=n.
module tb_es_mem_stream_reader;
    localparam int ADDR_W    = 15;
    localparam int MEM_WORDS = 25000;
    localparam int DEPTH     = 4;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    es_mem_stream_reader_if #(.ADDR_W(ADDR_W)) bus ();

    es_mem_stream_reader #(
        .MEM_WORDS (MEM_WORDS),
        .ADDR_W    (ADDR_W),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    beat_t       exp_q[$];
    beat_t       exp_b;
    int          beat_cyc[$];
    int          n_cmp       = 0;
    int          n_err       = 0;
    int          cyc         = 0;
    int          done_cnt    = 0;
    int          cs_cnt      = 0;
    int          beat_cnt    = 0;
    int          outstanding = 0;
    int          max_out     = 0;
    logic        prev_stall  = 1'b0;
    logic [31:0] prev_data   = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // RAM with word[n]=n, one-cycle read latency; junk when not selected
    always @(posedge clk) begin
        bus.mem_readdata <= bus.mem_chipselect ? 32'(bus.mem_address) : 32'hDEADBEEF;
    end

    // Monitor: pops the scoreboard on every accepted beat
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.done) done_cnt++;
            if (bus.mem_chipselect) begin
                cs_cnt++;
                outstanding++;
                if (outstanding > max_out) max_out = outstanding;
            end
            if (prev_stall) begin
                check("stall_valid_held", 64'(bus.st_valid), 64'(1));
                check("stall_data_held", 64'(bus.st_data), 64'(prev_data));
            end
            if (bus.st_valid && bus.st_ready) begin
                beat_cnt++;
                outstanding--;
                beat_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: got data %0h, required no beat", bus.st_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("beat_data_sop_eop",
                          64'({bus.st_data, bus.st_startofpacket, bus.st_endofpacket}),
                          64'(exp_b));
                end
            end
            prev_stall = bus.st_valid && !bus.st_ready && !bus.abort;
            prev_data  = bus.st_data;
        end
    end

    task automatic push_exp(input int b, input int l);
        for (int i = 0; i < l; i++) begin
            beat_t e;
            e.data = 32'((b + i) % MEM_WORDS);
            e.sop  = (i == 0);
            e.eop  = (i == l - 1);
            exp_q.push_back(e);
        end
    endtask

    // Base/length are scrambled right after the start edge; the captured values must hold.
    task automatic do_start(input int b, input int l);
        @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.base_addr = ADDR_W'(b);
        bus.length    = ADDR_W'(l);
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.base_addr = 15'h7FFF;
        bus.length    = 15'd3;
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
        check({name, "_timeout"}, 64'(k < 1000), 64'(1));
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_busy"}, 64'(bus.busy), 64'(0));
        check({name, "_done"}, 64'(bus.done), 64'(0));
        check({name, "_cs"}, 64'(bus.mem_chipselect), 64'(0));
        check({name, "_addr"}, 64'(bus.mem_address), 64'(0));
        check({name, "_valid"}, 64'(bus.st_valid), 64'(0));
        check({name, "_sop"}, 64'(bus.st_startofpacket), 64'(0));
        check({name, "_eop"}, 64'(bus.st_endofpacket), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dc0;
        int cs0;
        int b0;
        int acc;
        int k;

        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.base_addr = '0;
        bus.length    = '0;
        bus.st_ready  = 1'b1;

        #2;
        check_reset_outputs("reset");
        check("reset_const_write", 64'(bus.mem_write), 64'(0));
        check("reset_const_be", 64'(bus.mem_byteenable), 64'(4'hF));
        check("reset_const_clken", 64'(bus.mem_clken), 64'(1));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Basic transfer: latency, back-to-back beats, single done
        dc0 = done_cnt;
        beat_cyc.delete();
        push_exp(10, 8);
        do_start(10, 8);
        acc = cyc;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.st_valid) break;
        end
        check("first_valid_latency", 64'(cyc - acc), 64'(2));
        wait_idle("t1");
        check("t1_done_count", 64'(done_cnt - dc0), 64'(1));
        check("t1_queue_empty", 64'(exp_q.size()), 64'(0));
        check("t1_beat_count", 64'(beat_cyc.size()), 64'(8));
        if (beat_cyc.size() == 8)
            check("t1_beat_span", 64'(beat_cyc[7] - beat_cyc[0]), 64'(7));

        // Address wrap, plus a start while busy that must be ignored
        dc0 = done_cnt;
        push_exp(24998, 4);
        do_start(24998, 4);
        bus.start = 1'b1;
        bus.base_addr = 15'd500;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_idle("t2");
        check("t2_done_count", 64'(done_cnt - dc0), 64'(1));
        check("t2_queue_empty", 64'(exp_q.size()), 64'(0));

        // Toggling backpressure
        dc0 = done_cnt;
        outstanding = 0;
        max_out = 0;
        push_exp(40, 6);
        do_start(40, 6);
        for (k = 0; k < 300; k++) begin
            @(posedge clk);
            #1 bus.st_ready = ~bus.st_ready;
            if (!bus.busy) break;
        end
        bus.st_ready = 1'b1;
        check("t3_timeout", 64'(k < 300), 64'(1));
        repeat (3) @(negedge clk);
        check("t3_done_count", 64'(done_cnt - dc0), 64'(1));
        check("t3_queue_empty", 64'(exp_q.size()), 64'(0));
        check("t3_outstanding_le_depth", 64'(max_out <= DEPTH), 64'(1));

        // Zero length: done next cycle, nothing issued or streamed
        dc0 = done_cnt;
        cs0 = cs_cnt;
        b0  = beat_cnt;
        do_start(5, 0);
        @(negedge clk);
        check("t4_done_pulse", 64'(bus.done), 64'(1));
        check("t4_busy", 64'(bus.busy), 64'(0));
        @(negedge clk);
        check("t4_done_cleared", 64'(bus.done), 64'(0));
        repeat (4) @(negedge clk);
        check("t4_no_reads", 64'(cs_cnt - cs0), 64'(0));
        check("t4_no_beats", 64'(beat_cnt - b0), 64'(0));
        check("t4_done_count", 64'(done_cnt - dc0), 64'(1));

        // Abort after 20 beats while stalled
        dc0 = done_cnt;
        b0  = beat_cnt;
        push_exp(100, 100);
        do_start(100, 100);
        for (k = 0; k < 500; k++) begin
            @(posedge clk);
            #1;
            if (beat_cnt - b0 >= 20) begin
                bus.st_ready = 1'b0;
                break;
            end
        end
        check("t5_reach_20_timeout", 64'(k < 500), 64'(1));
        @(posedge clk);
        #1 bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        check("t5_valid_after_abort", 64'(bus.st_valid), 64'(0));
        check("t5_busy_after_abort", 64'(bus.busy), 64'(0));
        exp_q.delete();
        repeat (5) @(negedge clk);
        check("t5_no_done", 64'(done_cnt - dc0), 64'(0));
        check("t5_beats_before_abort", 64'(beat_cnt - b0), 64'(20));
        check("t5_valid_stays_low", 64'(bus.st_valid), 64'(0));
        bus.st_ready = 1'b1;
        dc0 = done_cnt;
        push_exp(0, 2);
        do_start(0, 2);
        wait_idle("t5b");
        check("t5b_done_count", 64'(done_cnt - dc0), 64'(1));
        check("t5b_queue_empty", 64'(exp_q.size()), 64'(0));

        // Asynchronous reset between clock edges, mid-transfer
        push_exp(50, 10);
        do_start(50, 10);
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1 check_reset_outputs("midreset");
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        dc0 = done_cnt;
        push_exp(7, 3);
        do_start(7, 3);
        wait_idle("t6");
        check("t6_done_count", 64'(done_cnt - dc0), 64'(1));
        check("t6_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
